hazard_stall_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage MIPS core.
- Detects load-use hazards, flushes the front end on taken branches, and holds the front end while a multi-cycle mult/div op completes in EX.
- Drives the PC write-enable, the IF/ID write-enable and flush, and a bubble select. The bubble select zeroes the WB (2b), MEM (3b) and EX (4b) control fields at the ID/EX register input.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl_pkg.sv | 19 +
 rtl/hazard_stall_ctrl_hazard_detect.sv | 21 ++
 rtl/hazard_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types and widths for the pipeline hazard/stall controller
package hazard_stall_ctrl_pkg;

    // Controller operating state: normal issue, or EX occupied by a mult/div op
    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Register-specifier width of the MIPS register file
    localparam int REG_W = 5;

    // Control-field widths zeroed by the bubble mux at the ID/EX register input
    localparam int WB_W   = 2;
    localparam int MEM_W  = 3;
    localparam int EX_W   = 4;
    localparam int CTRL_W = WB_W + MEM_W + EX_W;

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// rtl/hazard_stall_ctrl_hazard_detect.sv - combinational load-use hazard compare
import hazard_stall_ctrl_pkg::*;

module hazard_detect (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             load_use
);

    // A load into $zero never creates a dependency; rt only matters when ID reads it
    always_comb begin
        load_use = 1'b0;
        if (ex_mem_read && (ex_rt != '0)) begin
            load_use = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use stall, branch flush and mult/div hold control with stall counter
import hazard_stall_ctrl_pkg::*;

module hazard_stall_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int PERF_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              idex_mem_read,
    input  logic [REG_W-1:0]  idex_rt,
    input  logic              branch_taken,
    input  logic              id_muldiv,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              muldiv_busy,
    output logic              muldiv_done,
    output logic [PERF_W-1:0] stall_count
);

    localparam int               CNT_W    = $clog2(MULDIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             load_use;
    logic             issue;
    logic             done_raw;

    hazard_detect u_hazard (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (idex_mem_read),
        .ex_rt       (idex_rt),
        .load_use    (load_use)
    );

    // Mealy hazard outputs: branch flush beats load-use, which beats mult/div issue
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        muldiv_busy = 1'b0;
        done_raw    = 1'b0;
        issue       = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_muldiv) begin
                    issue    = 1'b1;
                    done_raw = (MULDIV_CYCLES == 1);
                end
            end
            BUSY: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                muldiv_busy = 1'b1;
                done_raw    = (count == CNT_ONE);
            end
            default: begin
                pc_write    = 1'b1;
            end
        endcase
    end

    // A reset cycle aborts any op in flight, so it must not report completion
    assign muldiv_done = done_raw && !reset;

    // State and mult/div down-counter; the last busy cycle returns to RUN
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (issue && (MULDIV_CYCLES > 1)) begin
                        state <= BUSY;
                        count <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (count == CNT_ONE) begin
                        state <= RUN;
                        count <= '0;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    state <= RUN;
                    count <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != PERF_MAX)) begin
            stall_count <= stall_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       id_uses_rt, idex_mem_read, branch_taken, id_muldiv;

    logic        pw [3];
    logic        iw [3];
    logic        fl [3];
    logic        bb [3];
    logic        by [3];
    logic        dn [3];
    logic [15:0] sc0;
    logic [1:0]  sc1;
    logic [15:0] sc2;

    int total = 0;
    int bad   = 0;

    int lat  [3] = '{4, 4, 1};
    int smax [3] = '{65535, 3, 65535};
    int left [3];
    int cnt  [3];

    always #5 clock = ~clock;

    hazard_stall_ctrl #(.MULDIV_CYCLES(4), .PERF_W(16)) u0 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken),
        .id_muldiv(id_muldiv), .pc_write(pw[0]), .ifid_write(iw[0]), .ifid_flush(fl[0]),
        .idex_bubble(bb[0]), .muldiv_busy(by[0]), .muldiv_done(dn[0]), .stall_count(sc0));

    hazard_stall_ctrl #(.MULDIV_CYCLES(4), .PERF_W(2)) u1 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken),
        .id_muldiv(id_muldiv), .pc_write(pw[1]), .ifid_write(iw[1]), .ifid_flush(fl[1]),
        .idex_bubble(bb[1]), .muldiv_busy(by[1]), .muldiv_done(dn[1]), .stall_count(sc1));

    hazard_stall_ctrl #(.MULDIV_CYCLES(1), .PERF_W(16)) u2 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken),
        .id_muldiv(id_muldiv), .pc_write(pw[2]), .ifid_write(iw[2]), .ifid_flush(fl[2]),
        .idex_bubble(bb[2]), .muldiv_busy(by[2]), .muldiv_done(dn[2]), .stall_count(sc2));

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    function automatic logic [31:0] sc_of(input int i);
        case (i)
            0:       return {16'b0, sc0};
            1:       return {30'b0, sc1};
            default: return {16'b0, sc2};
        endcase
    endfunction

    // One clock: drive inputs after the falling edge, check outputs against the model, advance the model
    task automatic cycle(input logic r, input logic b, input logic m, input logic mr,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                         input logic urt);
        logic lu, e_pw, e_iw, e_fl, e_bb, e_by, e_dn;
        @(negedge clock);
        reset = r; branch_taken = b; id_muldiv = m; idex_mem_read = mr;
        id_rs = rs; id_rt = rt; idex_rt = xrt; id_uses_rt = urt;
        #1;
        lu = mr && (xrt != 5'd0) && ((xrt == rs) || (urt && (xrt == rt)));
        chk("branch_in_busy", 0, {31'b0, b & by[0]}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            e_pw = 1; e_iw = 1; e_fl = 0; e_bb = 0; e_by = 0; e_dn = 0;
            if (left[i] > 0) begin
                e_pw = 0; e_iw = 0; e_bb = 1; e_by = 1; e_dn = (left[i] == 1) && !r;
            end else if (b) begin
                e_fl = 1; e_bb = 1;
            end else if (lu) begin
                e_pw = 0; e_iw = 0; e_bb = 1;
            end else if (m) begin
                e_dn = (lat[i] == 1) && !r;
            end
            chk("pc_write",    i, {31'b0, pw[i]}, {31'b0, e_pw});
            chk("ifid_write",  i, {31'b0, iw[i]}, {31'b0, e_iw});
            chk("ifid_flush",  i, {31'b0, fl[i]}, {31'b0, e_fl});
            chk("idex_bubble", i, {31'b0, bb[i]}, {31'b0, e_bb});
            chk("muldiv_busy", i, {31'b0, by[i]}, {31'b0, e_by});
            chk("muldiv_done", i, {31'b0, dn[i]}, {31'b0, e_dn});
            chk("stall_count", i, sc_of(i), cnt[i]);
            if (r) begin
                left[i] = 0;
                cnt[i]  = 0;
            end else begin
                if (!e_pw && cnt[i] < smax[i]) cnt[i] = cnt[i] + 1;
                if (left[i] > 0) left[i] = left[i] - 1;
                else if (!b && !lu && m && lat[i] > 1) left[i] = lat[i] - 1;
            end
        end
        @(posedge clock);
    endtask

    initial begin
        reset = 1; branch_taken = 0; id_muldiv = 0; idex_mem_read = 0;
        id_rs = 0; id_rt = 0; idex_rt = 0; id_uses_rt = 0;
        for (int i = 0; i < 3; i++) begin left[i] = 0; cnt[i] = 0; end
        @(posedge clock);

        // reset then idle
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs, then resume
        cycle(0, 0, 0, 1, 5'd8, 0, 5'd8, 0);
        cycle(0, 0, 0, 0, 5'd8, 0, 5'd8, 0);
        chk("count_after_lu", 0, {16'b0, sc0}, 32'd1);
        // load to $zero never stalls
        cycle(0, 0, 0, 1, 5'd0, 0, 5'd0, 0);
        // rt compare only when ID reads rt
        cycle(0, 0, 0, 1, 5'd1, 5'd9, 5'd9, 0);
        cycle(0, 0, 0, 1, 5'd1, 5'd9, 5'd9, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // branch beats load-use and mult/div
        cycle(0, 1, 1, 1, 5'd8, 0, 5'd8, 0);
        // single mult/div: 3 busy cycles on the 4-cycle units
        cycle(0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-busy aborts without a done pulse
        cycle(0, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // back-to-back mult/div held in ID
        for (int k = 0; k < 9; k++) cycle(0, 0, 1, 0, 0, 0, 0, 0);
        // saturation: five held load-use cycles from a clean count
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, 5'd3, 0, 5'd3, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_count_wide", 0, {16'b0, sc0}, 32'd5);
        chk("sat_count_narrow", 1, {30'b0, sc1}, 32'd3);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic r, b, m, mr, urt;
            logic [4:0] rs, rt, xrt;
            r   = ($urandom_range(0, 49) == 0);
            b   = (left[0] == 0) && ($urandom_range(0, 7) == 0);
            m   = ($urandom_range(0, 3) == 0);
            mr  = ($urandom_range(0, 1) == 1);
            urt = ($urandom_range(0, 1) == 1);
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            xrt = 5'($urandom_range(0, 3));
            cycle(r, b, m, mr, rs, rt, xrt, urt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
